branch_predictor: RTL and testbench

//  Direct-mapped branch target buffer with 2-bit saturating counters. It sits directly

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is purely combinational on fetch_pc; training happens on the clock
// edge from branches resolved in the memory stage. Two saturating counters
// keep statistics on resolved branches and mispredictions.
//
// Update interface: upd_en is a single-cycle qualifier with no back-pressure.
// When upd_en is high on a rising CLK edge, upd_pc/upd_taken/upd_target/
// upd_mispred are consumed on that edge; when it is low they are ignored.
// flush is an independent qualifier sampled on the same edge.
module branch_predictor #(
  parameter int ENTRIES = 8,
  // Width of the statistics counters; they saturate at all-ones of this
  // width and are zero-extended onto the 32-bit outputs.
  parameter int STAT_W  = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_addr,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Entry storage
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  // Statistics
  logic [STAT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  // Address decomposition; the two byte-offset bits take no part.
  logic [IDX_W-1:0]   f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               f_hit;
  logic               u_hit;
  logic               unused_low_bits;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign unused_low_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Lookup: reads only registered state, so an update landing this cycle is
  // not visible until the next one.
  always_comb begin
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken = f_hit && ctr_q[f_idx][1];
    pred_addr  = pred_taken ? target_q[f_idx] : (fetch_pc + 32'd4);
  end

  // Hit detection for the entry being trained.
  always_comb begin
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  end

  // Next-state for the entry array: train or allocate, then flush overrides
  // the valid bits while leaving tag/target/counter contents in place.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != CTR_ST) begin
            ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          end
          target_d[u_idx] = upd_target;
        end else begin
          if (ctr_q[u_idx] != CTR_SNT) begin
            ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
          end
        end
      end else begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = upd_taken ? CTR_WT : CTR_WNT;
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Next-state for the statistics: count every resolved branch, saturating.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
      end
      if (upd_mispred && (mispred_cnt_q != '1)) begin
        mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = 32'(branch_cnt_q);
  assign mispred_cnt = 32'(mispred_cnt_q);

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A behavioural model of the BTB
// produces the expected prediction each cycle; expectations go through a
// scoreboard queue and are compared against the DUT outputs. A second
// instance with narrow statistics counters exercises counter saturation.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush;

  logic        pred_taken;
  logic [31:0] pred_addr;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic        pred_taken_n;
  logic [31:0] pred_addr_n;
  logic [31:0] branch_cnt_n;
  logic [31:0] mispred_cnt_n;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];

  // Reference model state
  logic        m_valid  [8];
  logic [26:0] m_tag    [8];
  logic [31:0] m_target [8];
  logic [1:0]  m_ctr    [8];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;
  logic [3:0]  m2_bcnt;
  logic [3:0]  m2_mcnt;

  branch_predictor #(.ENTRIES(8)) dut (
    .CLK(clk), .RST(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_addr(pred_addr),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .flush(flush),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.ENTRIES(8), .STAT_W(4)) dut_narrow (
    .CLK(clk), .RST(rst), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken_n), .pred_addr(pred_addr_n),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .flush(flush),
    .branch_cnt(branch_cnt_n), .mispred_cnt(mispred_cnt_n)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 2'b01;
    end
    m_bcnt  = '0;
    m_mcnt  = '0;
    m2_bcnt = '0;
    m2_mcnt = '0;
  endtask

  // Drive one cycle of inputs at the falling edge and score the outputs.
  task automatic drive(input logic [31:0] fpc, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um,
                       input logic fl);
    logic [2:0]  idx;
    logic        hit;
    logic        et;
    logic [31:0] ea;
    logic [32:0] exp_v;
    @(negedge clk);
    fetch_pc    = fpc;
    upd_en      = ue;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utgt;
    upd_mispred = um;
    flush       = fl;
    idx = fpc[4:2];
    hit = m_valid[idx] && (m_tag[idx] == fpc[31:5]);
    et  = hit && m_ctr[idx][1];
    ea  = et ? m_target[idx] : fpc + 32'd4;
    exp_q.push_back({et, ea});
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({pred_taken, pred_addr} !== exp_v) begin
      failures++;
      $display("FAIL pred pc=%h: got taken=%b addr=%h expected taken=%b addr=%h",
               fpc, pred_taken, pred_addr, exp_v[32], exp_v[31:0]);
    end
    checks++;
    if ({pred_taken_n, pred_addr_n} !== exp_v) begin
      failures++;
      $display("FAIL pred_narrow pc=%h: got %b/%h expected %b/%h",
               fpc, pred_taken_n, pred_addr_n, exp_v[32], exp_v[31:0]);
    end
    checks++;
    if (branch_cnt !== m_bcnt) begin
      failures++;
      $display("FAIL branch_cnt: got %0d expected %0d", branch_cnt, m_bcnt);
    end
    checks++;
    if (mispred_cnt !== m_mcnt) begin
      failures++;
      $display("FAIL mispred_cnt: got %0d expected %0d", mispred_cnt, m_mcnt);
    end
    checks++;
    if (branch_cnt_n !== {28'd0, m2_bcnt} || mispred_cnt_n !== {28'd0, m2_mcnt}) begin
      failures++;
      $display("FAIL narrow_cnt: got %0d/%0d expected %0d/%0d",
               branch_cnt_n, mispred_cnt_n, m2_bcnt, m2_mcnt);
    end
  endtask

  // Advance past the rising edge and apply the same update to the model.
  task automatic commit();
    logic [2:0] idx;
    logic       hit;
    @(posedge clk);
    #1;
    if (upd_en) begin
      idx = upd_pc[4:2];
      hit = m_valid[idx] && (m_tag[idx] == upd_pc[31:5]);
      if (hit) begin
        if (upd_taken) begin
          if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
          m_target[idx] = upd_target;
        end else if (m_ctr[idx] != 2'b00) begin
          m_ctr[idx] = m_ctr[idx] - 2'd1;
        end
      end else begin
        m_valid[idx]  = 1'b1;
        m_tag[idx]    = upd_pc[31:5];
        m_target[idx] = upd_target;
        m_ctr[idx]    = upd_taken ? 2'b10 : 2'b01;
      end
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
      if (m2_bcnt != 4'hF) m2_bcnt = m2_bcnt + 4'd1;
      if (upd_mispred) begin
        if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
        if (m2_mcnt != 4'hF) m2_mcnt = m2_mcnt + 4'd1;
      end
    end
    if (flush) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    commit();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    upd_en = 1'b0;
    flush  = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_pc = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispred = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h44) begin
      failures++;
      $display("FAIL reset_pred: got %b/%h expected 0/00000044", pred_taken, pred_addr);
    end
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(32'h40);
    drive(32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_addr !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: got %h expected 00000000", pred_addr);
    end
    commit();
  endtask

  task automatic test_train();
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    commit();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b1 || pred_addr !== 32'h100) begin
      failures++;
      $display("FAIL train: got %b/%h expected 1/00000100", pred_taken, pred_addr);
    end
    commit();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
      commit();
    end
    drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 1'b0);
    commit();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b1 || pred_addr !== 32'h100) begin
      failures++;
      $display("FAIL sat_one_nt: got %b/%h expected 1/00000100", pred_taken, pred_addr);
    end
    commit();
    drive(32'h41, 1'b1, 32'h42, 1'b0, 32'h999, 1'b1, 1'b0);
    commit();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h44) begin
      failures++;
      $display("FAIL sat_two_nt: got %b/%h expected 0/00000044", pred_taken, pred_addr);
    end
    commit();
  endtask

  task automatic test_alias();
    drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    commit();
    drive(32'h0, 1'b1, 32'h60, 1'b1, 32'h200, 1'b0, 1'b0);
    commit();
    drive(32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h44) begin
      failures++;
      $display("FAIL alias_old: got %b/%h expected 0/00000044", pred_taken, pred_addr);
    end
    commit();
    drive(32'h60, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b1 || pred_addr !== 32'h200) begin
      failures++;
      $display("FAIL alias_new: got %b/%h expected 1/00000200", pred_taken, pred_addr);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass: got %b expected 0", pred_taken);
    end
    commit();
    drive(32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b1 || pred_addr !== 32'h300) begin
      failures++;
      $display("FAIL after_update: got %b/%h expected 1/00000300", pred_taken, pred_addr);
    end
    commit();
  endtask

  task automatic test_flush();
    logic [31:0] b0;
    logic [31:0] m0;
    b0 = m_bcnt;
    m0 = m_mcnt;
    drive(32'h60, 1'b1, 32'h80, 1'b1, 32'h500, 1'b1, 1'b1);
    commit();
    drive(32'h60, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h64) begin
      failures++;
      $display("FAIL flush_60: got %b/%h expected 0/00000064", pred_taken, pred_addr);
    end
    checks++;
    if (branch_cnt !== b0 + 32'd1 || mispred_cnt !== m0 + 32'd1) begin
      failures++;
      $display("FAIL flush_stats: got %0d/%0d expected %0d/%0d",
               branch_cnt, mispred_cnt, b0 + 32'd1, m0 + 32'd1);
    end
    commit();
    drive(32'h80, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (pred_taken !== 1'b0 || pred_addr !== 32'h84) begin
      failures++;
      $display("FAIL flush_80: got %b/%h expected 0/00000084", pred_taken, pred_addr);
    end
    commit();
  endtask

  task automatic test_stat_saturate();
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      drive(32'h10, 1'b1, 32'h10 + 32'(i * 4), 1'b1, 32'h700, 1'b1, 1'b0);
      commit();
    end
    drive(32'h10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (branch_cnt_n !== 32'd15 || mispred_cnt_n !== 32'd15) begin
      failures++;
      $display("FAIL narrow_sat: got %0d/%0d expected 15/15", branch_cnt_n, mispred_cnt_n);
    end
    checks++;
    if (branch_cnt !== 32'd20 || mispred_cnt !== 32'd20) begin
      failures++;
      $display("FAIL wide_cnt: got %0d/%0d expected 20/20", branch_cnt, mispred_cnt);
    end
    commit();
    drive(32'h10, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
    commit();
  endtask

  task automatic test_random();
    logic [31:0] fpc;
    logic [31:0] upc;
    for (int i = 0; i < 400; i++) begin
      fpc = {27'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      upc = {27'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      drive(fpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
      commit();
    end
  endtask

  task automatic test_reset_mid();
    drive(32'h20, 1'b1, 32'h20, 1'b1, 32'h800, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0 || pred_taken !== 1'b0 ||
        pred_addr !== 32'h24) begin
      failures++;
      $display("FAIL mid_reset: got %0d/%0d %b/%h expected 0/0 0/00000024",
               branch_cnt, mispred_cnt, pred_taken, pred_addr);
    end
    @(negedge clk);
    rst    = 1'b0;
    upd_en = 1'b0;
    idle(32'h20);
    idle(32'h20);
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_back_to_back();
    test_flush();
    test_stat_saturate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
